// File: rtl/mcp3008_responder.sv
// mcp3008_responder: clk-synchronous stand-in for the slave side of an MCP3008
// SPI ADC. It decodes start/SGL/D2..D0 from din_i and answers on dout with a
// null bit and then a 10-bit value taken from the parallel ch_data bus.
// Optional feature macro: MCP3008_LSB_TAIL_EN. When it is defined, the frame
// tail repeats B1..B9 LSB-first as the real device does. When it is undefined,
// the tail drives zeros.
module mcp3008_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ad_clk_i,
    input  logic                cs_i,
    input  logic                din_i,
    input  logic [8*DATA_W-1:0] ch_data,
    output logic                dout,
    output logic                dout_oe,
    output logic                conv_valid,
    output logic [2:0]          conv_ch,
    output logic                conv_sgl,
    output logic [DATA_W-1:0]   conv_data,
    output logic                frame_err
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT_START, ST_CMD, ST_SAMPLE, ST_NULL, ST_DATA, ST_TAIL
    } state_e;

    // Synchronizer chain for {ad_clk, cs, din}; the last stage is the synced value.
    logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
    logic [1:0]                  prev_q, prev_d;    // previous synced {ad_clk, cs}
    logic                        ad_s, cs_s, din_s;
    logic                        cs_rise, cs_fall, ad_rise_en, ad_fall_en;

    state_e              state_q, state_d;
    logic [3:0]          cmd_q, cmd_d;              // {SGL, D2, D1, D0}
    logic [3:0]          bit_idx_q, bit_idx_d;
    logic                dout_q, dout_d;
    logic                dout_oe_q, dout_oe_d;
    logic                conv_valid_q, conv_valid_d;
    logic [2:0]          conv_ch_q, conv_ch_d;
    logic                conv_sgl_q, conv_sgl_d;
    logic [DATA_W-1:0]   conv_data_q, conv_data_d;
    logic                frame_err_q, frame_err_d;

    logic [DATA_W-1:0]   ch_arr [8];
    logic [DATA_W-1:0]   val_p, val_m, sel_value;

    // Shift the pins into the synchronizer and remember the previous synced level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ad_clk_i, cs_i, din_i};
        prev_d = sync_q[SYNC_STAGES-1][2:1];
    end

    // NOTE: the synchronizer and edge history are left unreset on purpose. They
    // only track the pins, so they never flag an edge the pins did not make. A
    // cs that is already low at the end of reset therefore never looks like a
    // frame start.
    always_ff @(posedge clk) begin
        sync_q <= sync_d;
        prev_q <= prev_d;
    end

    // Edge qualification: cs edges take priority, and ad_clk counts only while cs is low.
    always_comb begin
        {ad_s, cs_s, din_s} = sync_q[SYNC_STAGES-1];
        cs_rise    =  cs_s & ~prev_q[0];
        cs_fall    = ~cs_s &  prev_q[0];
        ad_rise_en =  ad_s & ~prev_q[1] & ~cs_s;
        ad_fall_en = ~ad_s &  prev_q[1] & ~cs_s;
    end

    // Channel select and saturating differential subtraction for the latched command.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            ch_arr[i] = ch_data[i*DATA_W +: DATA_W];
        end
        val_p     = ch_arr[cmd_q[2:0]];
        val_m     = ch_arr[{cmd_q[2:1], ~cmd_q[0]}];
        sel_value = cmd_q[3] ? val_p : ((val_p > val_m) ? (val_p - val_m) : '0);
    end

    // Frame FSM: next state and next output values.
    always_comb begin
        // NOTE: every variable gets its hold or idle value first, so no path
        // through the case statement can infer a latch.
        state_d      = state_q;
        cmd_d        = cmd_q;
        bit_idx_d    = bit_idx_q;
        dout_d       = dout_q;
        dout_oe_d    = dout_oe_q;
        conv_ch_d    = conv_ch_q;
        conv_sgl_d   = conv_sgl_q;
        conv_data_d  = conv_data_q;
        conv_valid_d = 1'b0;
        frame_err_d  = 1'b0;

        if (cs_rise) begin
            state_d     = ST_IDLE;
            dout_d      = 1'b0;
            dout_oe_d   = 1'b0;
            frame_err_d = (state_q == ST_CMD)  || (state_q == ST_SAMPLE) ||
                          (state_q == ST_NULL) || (state_q == ST_DATA);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) state_d = ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (ad_rise_en && din_s) begin
                        state_d   = ST_CMD;
                        bit_idx_d = '0;
                    end
                end
                ST_CMD: begin
                    if (ad_rise_en) begin
                        cmd_d     = {cmd_q[2:0], din_s};
                        bit_idx_d = bit_idx_q + 4'd1;
                        if (bit_idx_q == 4'd3) state_d = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (ad_fall_en) begin
                        conv_data_d  = sel_value;
                        conv_ch_d    = cmd_q[2:0];
                        conv_sgl_d   = cmd_q[3];
                        conv_valid_d = 1'b1;
                        dout_oe_d    = 1'b1;
                        dout_d       = 1'b0;
                        state_d      = ST_NULL;
                    end
                end
                ST_NULL: begin
                    if (ad_fall_en) begin
                        dout_d    = conv_data_q[DATA_W-1];
                        bit_idx_d = 4'(DATA_W - 2);
                        state_d   = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (ad_fall_en) begin
                        dout_d = conv_data_q[bit_idx_q];
                        if (bit_idx_q == 4'd0) begin
                            bit_idx_d = 4'd1;
                            state_d   = ST_TAIL;
                        end else begin
                            bit_idx_d = bit_idx_q - 4'd1;
                        end
                    end
                end
                ST_TAIL: begin
`ifdef MCP3008_LSB_TAIL_EN
                    if (ad_fall_en) begin
                        if (bit_idx_q < 4'(DATA_W)) begin
                            dout_d    = conv_data_q[bit_idx_q];
                            bit_idx_d = bit_idx_q + 4'd1;
                        end else begin
                            dout_d = 1'b0;
                        end
                    end
`else
                    if (ad_fall_en) dout_d = 1'b0;
`endif
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            bit_idx_q    <= '0;
            dout_q       <= 1'b0;
            dout_oe_q    <= 1'b0;
            conv_valid_q <= 1'b0;
            conv_ch_q    <= '0;
            conv_sgl_q   <= 1'b0;
            conv_data_q  <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            bit_idx_q    <= bit_idx_d;
            dout_q       <= dout_d;
            dout_oe_q    <= dout_oe_d;
            conv_valid_q <= conv_valid_d;
            conv_ch_q    <= conv_ch_d;
            conv_sgl_q   <= conv_sgl_d;
            conv_data_q  <= conv_data_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign dout       = dout_q;
    assign dout_oe    = dout_oe_q;
    assign conv_valid = conv_valid_q;
    assign conv_ch    = conv_ch_q;
    assign conv_sgl   = conv_sgl_q;
    assign conv_data  = conv_data_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_mcp3008_responder.sv
// Testbench for mcp3008_responder. A directed SPI controller issues the
// frames and pushes the hand-computed response into scoreboards. Independent
// monitors pop the scoreboards and compare against conv_valid, frame_err and
// the dout bits sampled on rising ad_clk edges.
module tb_mcp3008_responder;

    localparam int SYNC = 2;
    localparam int HALF = 8;   // ad_clk half period in clk cycles (ad_clk = clk/16)

    typedef struct packed {
        logic [2:0] ch;
        logic       sgl;
        logic [9:0] data;
    } conv_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ad_clk_i, cs_i, din_i;
    logic [79:0] ch_data;
    logic       dout, dout_oe, conv_valid, conv_sgl, frame_err;
    logic [2:0] conv_ch;
    logic [9:0] conv_data;

    int    n_checks = 0;
    int    n_pass   = 0;
    conv_t exp_conv_q[$];
    logic  exp_bit_q[$];
    int    err_pending = 0;
    conv_t mon_conv;
    logic  mon_bit;

    mcp3008_responder #(.SYNC_STAGES(SYNC), .DATA_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .ad_clk_i   (ad_clk_i),
        .cs_i       (cs_i),
        .din_i      (din_i),
        .ch_data    (ch_data),
        .dout       (dout),
        .dout_oe    (dout_oe),
        .conv_valid (conv_valid),
        .conv_ch    (conv_ch),
        .conv_sgl   (conv_sgl),
        .conv_data  (conv_data),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic set_ch(input int n, input logic [9:0] val);
        ch_data[n*10 +: 10] = val;
    endtask

    // Monitor: conversion latch and frame error pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (conv_valid) begin
                if (exp_conv_q.size() == 0) begin
                    check("conv_valid_unexpected", {31'd0, conv_valid}, 32'd0);
                end else begin
                    mon_conv = exp_conv_q.pop_front();
                    check("conv_ch",   {29'd0, conv_ch},   {29'd0, mon_conv.ch});
                    check("conv_sgl",  {31'd0, conv_sgl},  {31'd0, mon_conv.sgl});
                    check("conv_data", {22'd0, conv_data}, {22'd0, mon_conv.data});
                end
            end
            if (frame_err) begin
                check("frame_err_expected", (err_pending > 0) ? 32'd1 : 32'd0, 32'd1);
                if (err_pending > 0) err_pending--;
            end
        end
    end

    // Monitor: the controller's receive side, sampling dout on rising ad_clk.
    always @(posedge ad_clk_i) begin
        if (!cs_i && dout_oe) begin
            if (exp_bit_q.size() == 0) begin
                check("dout_unexpected", {31'd0, dout_oe}, 32'd0);
            end else begin
                mon_bit = exp_bit_q.pop_front();
                check("dout_bit", {31'd0, dout}, {31'd0, mon_bit});
            end
        end
    end

    // One controller frame: lead zeros, start, SGL, D2..D0, then zeros up to n_edges rising edges.
    task automatic run_frame(input int lead, input logic sgl, input logic [2:0] ch,
                             input int n_edges, input logic [9:0] exp_data);
        logic [4:0] cmd;
        logic       b;
        cmd = {1'b1, sgl, ch};
        if (n_edges >= lead + 5) exp_conv_q.push_back('{ch, sgl, exp_data});
        for (int r = lead + 5; r < n_edges; r++) begin
            int j;
            j = r - (lead + 5);
            if (j == 0) b = 1'b0;
            else if (j <= 10) b = exp_data[10 - j];
            else begin
`ifdef MCP3008_LSB_TAIL_EN
                b = (j - 10 <= 9) ? exp_data[j - 10] : 1'b0;
`else
                b = 1'b0;
`endif
            end
            exp_bit_q.push_back(b);
        end
        if (n_edges >= lead + 1 && n_edges <= lead + 14) err_pending++;

        @(negedge clk) cs_i = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int r = 0; r < n_edges; r++) begin
            din_i = (r < lead) ? 1'b0 : ((r < lead + 5) ? cmd[4 - (r - lead)] : 1'b0);
            repeat (HALF) @(negedge clk);
            ad_clk_i = 1'b1;
            repeat (HALF) @(negedge clk);
            ad_clk_i = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        cs_i  = 1'b1;
        din_i = 1'b0;
        repeat (SYNC + 2) @(posedge clk);
        #1;
        check("dout_oe_after_cs", {31'd0, dout_oe}, 32'd0);
        check("bits_left",        exp_bit_q.size(),  32'd0);
        check("conv_left",        exp_conv_q.size(), 32'd0);
        check("frame_err_left",   err_pending,       32'd0);
        repeat (4) @(negedge clk);
    endtask

    // Watchdog: every wait above is a fixed count, so this only trips on a broken bench.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        cs_i     = 1'b1;
        ad_clk_i = 1'b0;
        din_i    = 1'b0;
        ch_data  = '0;
        repeat (5) @(negedge clk);
        check("rst_dout",       {31'd0, dout},       32'd0);
        check("rst_dout_oe",    {31'd0, dout_oe},    32'd0);
        check("rst_conv_valid", {31'd0, conv_valid}, 32'd0);
        check("rst_conv_ch",    {29'd0, conv_ch},    32'd0);
        check("rst_conv_sgl",   {31'd0, conv_sgl},   32'd0);
        check("rst_conv_data",  {22'd0, conv_data},  32'd0);
        check("rst_frame_err",  {31'd0, frame_err},  32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single-ended read of CH5: null 0, then 1010100101, then tail.
        set_ch(5, 10'h2A5);
        run_frame(0, 1'b1, 3'd5, 32, 10'h2A5);

        // Differential: CH2-CH3 clips to 0, CH3-CH2 = 200.
        set_ch(2, 10'd100);
        set_ch(3, 10'd300);
        run_frame(0, 1'b0, 3'd2, 24, 10'd0);
        run_frame(0, 1'b0, 3'd3, 24, 10'd200);

        // Seven leading zeros before the start bit, CH0 full scale.
        set_ch(0, 10'h3FF);
        run_frame(7, 1'b1, 3'd0, 23, 10'h3FF);

        // Abort after B6 is driven (rising edges 0..8), then a clean CH7 read.
        set_ch(4, 10'h155);
        run_frame(0, 1'b1, 3'd4, 9, 10'h155);
        set_ch(7, 10'd1);
        run_frame(0, 1'b1, 3'd7, 16, 10'd1);

        // Reset during CMD with cs held low: the rest of the frame is ignored.
        @(negedge clk) cs_i = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int r = 0; r < 24; r++) begin
            din_i = (r < 3) ? 1'b1 : 1'b0;
            repeat (HALF) @(negedge clk);
            ad_clk_i = 1'b1;
            repeat (HALF) @(negedge clk);
            ad_clk_i = 1'b0;
            if (r == 2) begin
                rst = 1'b1;
                @(negedge clk) rst = 1'b0;
                check("rst_mid_conv_data", {22'd0, conv_data}, 32'd0);
                check("rst_mid_conv_ch",   {29'd0, conv_ch},   32'd0);
            end
        end
        check("rst_mid_no_oe", {31'd0, dout_oe}, 32'd0);
        repeat (HALF) @(negedge clk);
        cs_i  = 1'b1;
        din_i = 1'b0;
        repeat (SYNC + 4) @(negedge clk);
        check("rst_mid_bits_left", exp_bit_q.size(), 32'd0);
        check("rst_mid_err_left",  err_pending,      32'd0);

        // Tail: six rising edges after B0, CH1 = 0x301.
        set_ch(1, 10'h301);
        run_frame(0, 1'b1, 3'd1, 22, 10'h301);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
